adc_acq_ctrl: RTL and testbench

//  Acquisition sequencer for the ADC interface block. On a host start it programs the ADC

---
 rtl/adc_acq_ctrl_pkg.sv | 23 ++
 rtl/adc_sample_fifo.sv | 75 +++++++
 rtl/adc_acq_ctrl.sv | 197 +++++++++++++++++++
 tb/tb_adc_acq_ctrl.sv | 414 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/adc_acq_ctrl_pkg.sv
// Shared types and widths for the ADC acquisition sequencer.
package adc_acq_ctrl_pkg;

    localparam int CTRL_W  = 10;
    localparam int DF_W    = 16;
    localparam int DATA_W  = 32;
    localparam int ENTRY_W = DATA_W + 1;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_PROG   = 3'd1,
        ST_SETTLE = 3'd2,
        ST_ACQ    = 3'd3,
        ST_DRAIN  = 3'd4,
        ST_DONE   = 3'd5
    } acq_state_e;

    // A downsampling factor of zero is meaningless to the ADC, so treat it as "no downsampling".
    function automatic logic [DF_W-1:0] effective_df(input logic [DF_W-1:0] df);
        return (df == '0) ? DF_W'(1) : df;
    endfunction

endpackage

// File: rtl/adc_sample_fifo.sv
// Synchronous first-word-fall-through FIFO. The head word is visible on dout whenever empty is low.
// Full is judged on the registered count, so a write into a full FIFO is dropped even if a
// read frees a slot in the same cycle.
module adc_sample_fifo #(
    parameter int WIDTH = 33,
    parameter int DEPTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] din,
    output logic             full,
    input  logic             rd_en,
    output logic [WIDTH-1:0] dout,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic             do_wr;
    logic             do_rd;

    assign full  = (count_q == (AW+1)'(DEPTH));
    assign empty = (count_q == '0);
    assign dout  = mem_q[rd_ptr_q];
    assign do_wr = wr_en & ~full;
    assign do_rd = rd_en & ~empty;

    // Pointer and occupancy update; flush discards everything in one cycle.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_wr) wr_ptr_d = wr_ptr_q + AW'(1);
            if (do_rd) rd_ptr_d = rd_ptr_q + AW'(1);
            count_d = count_q + (AW+1)'(do_wr) - (AW+1)'(do_rd);
        end
    end

    // Storage write path; contents need no reset because empty masks them.
    always_comb begin
        mem_d = mem_q;
        if (do_wr && !flush) mem_d[wr_ptr_q] = din;
    end

    // Pointer and count registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage array register.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

endmodule

// File: rtl/adc_acq_ctrl.sv
// Acquisition sequencer: programs the ADC, waits for it to settle, captures a fixed number of
// channel-A samples and streams them out through a small FWFT FIFO.
module adc_acq_ctrl
    import adc_acq_ctrl_pkg::*;
#(
    parameter int CFG_WAIT   = 256,
    parameter int FIFO_DEPTH = 16,
    parameter int CNT_W      = 24
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    input  logic [CTRL_W-1:0] cfg_ctrlword,
    input  logic [DF_W-1:0]   cfg_df,
    input  logic [CNT_W-1:0]  cfg_nsamp,
    output logic              busy,
    output logic              done,
    output logic              ovf,
    output logic [CNT_W-1:0]  sample_cnt,
    output logic [CTRL_W-1:0] adc_ctrlword,
    output logic              adc_ldctrl,
    output logic [DF_W-1:0]   adc_df,
    output logic              adc_enable,
    input  logic [DATA_W-1:0] adc_douta,
    input  logic              adc_valida,
    output logic [DATA_W-1:0] m_data,
    output logic              m_valid,
    input  logic              m_ready,
    output logic              m_last
);

    localparam int TMR_W = $clog2(CFG_WAIT + 1);

    acq_state_e        state_q, state_d;
    logic [TMR_W-1:0]  timer_q, timer_d;
    logic [CTRL_W-1:0] ctrlword_q, ctrlword_d;
    logic [DF_W-1:0]   df_q, df_d;
    logic [CNT_W-1:0]  nsamp_q, nsamp_d;
    logic [CNT_W-1:0]  captured_q, captured_d;
    logic [CNT_W-1:0]  sample_cnt_q, sample_cnt_d;
    logic              ovf_q, ovf_d;
    logic              done_q, done_d;
    logic              ldctrl_q, ldctrl_d;
    logic              enable_q, enable_d;

    logic               is_last_strobe;
    logic               fifo_wr;
    logic               fifo_flush;
    logic               fifo_full;
    logic               fifo_empty;
    logic [ENTRY_W-1:0] fifo_dout;

    assign is_last_strobe = (captured_q == nsamp_q - CNT_W'(1));

    adc_sample_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .flush (fifo_flush),
        .wr_en (fifo_wr),
        .din   ({is_last_strobe, adc_douta}),
        .full  (fifo_full),
        .rd_en (m_ready),
        .dout  (fifo_dout),
        .empty (fifo_empty)
    );

    assign busy         = (state_q != ST_IDLE);
    assign done         = done_q;
    assign ovf          = ovf_q;
    assign sample_cnt   = sample_cnt_q;
    assign adc_ctrlword = ctrlword_q;
    assign adc_ldctrl   = ldctrl_q;
    assign adc_df       = df_q;
    assign adc_enable   = enable_q;
    assign m_valid      = ~fifo_empty;
    assign m_data       = fifo_empty ? '0 : fifo_dout[DATA_W-1:0];
    assign m_last       = ~fifo_empty & fifo_dout[DATA_W];

    // Sequencer next-state, counters and registered ADC controls; abort overrides everything.
    always_comb begin
        state_d      = state_q;
        timer_d      = timer_q;
        ctrlword_d   = ctrlword_q;
        df_d         = df_q;
        nsamp_d      = nsamp_q;
        captured_d   = captured_q;
        sample_cnt_d = sample_cnt_q;
        ovf_d        = ovf_q;
        enable_d     = enable_q;
        done_d       = 1'b0;
        ldctrl_d     = 1'b0;
        fifo_wr      = 1'b0;
        fifo_flush   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start && !abort) begin
                    ctrlword_d   = cfg_ctrlword;
                    df_d         = effective_df(cfg_df);
                    nsamp_d      = cfg_nsamp;
                    ovf_d        = 1'b0;
                    sample_cnt_d = '0;
                    captured_d   = '0;
                    if (cfg_nsamp == '0) begin
                        state_d = ST_DONE;
                        done_d  = 1'b1;
                    end else begin
                        state_d  = ST_PROG;
                        ldctrl_d = 1'b1;
                    end
                end
            end
            ST_PROG: begin
                state_d = ST_SETTLE;
                timer_d = TMR_W'(CFG_WAIT - 1);
            end
            ST_SETTLE: begin
                if (timer_q == '0) begin
                    state_d  = ST_ACQ;
                    enable_d = 1'b1;
                end else begin
                    timer_d = timer_q - TMR_W'(1);
                end
            end
            ST_ACQ: begin
                if (adc_valida) begin
                    if (captured_q != nsamp_q) captured_d = captured_q + CNT_W'(1);
                    if (fifo_full) begin
                        ovf_d = 1'b1;
                    end else begin
                        fifo_wr = 1'b1;
                        if (sample_cnt_q != nsamp_q) sample_cnt_d = sample_cnt_q + CNT_W'(1);
                    end
                    if (is_last_strobe) begin
                        enable_d = 1'b0;
                        state_d  = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                if (fifo_empty) begin
                    state_d = ST_DONE;
                    done_d  = 1'b1;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (abort && state_q != ST_IDLE) begin
            state_d    = ST_IDLE;
            enable_d   = 1'b0;
            ldctrl_d   = 1'b0;
            done_d     = 1'b0;
            fifo_wr    = 1'b0;
            fifo_flush = 1'b1;
        end
    end

    // State, configuration and counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            timer_q      <= '0;
            ctrlword_q   <= '0;
            df_q         <= '0;
            nsamp_q      <= '0;
            captured_q   <= '0;
            sample_cnt_q <= '0;
            ovf_q        <= 1'b0;
            done_q       <= 1'b0;
            ldctrl_q     <= 1'b0;
            enable_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            timer_q      <= timer_d;
            ctrlword_q   <= ctrlword_d;
            df_q         <= df_d;
            nsamp_q      <= nsamp_d;
            captured_q   <= captured_d;
            sample_cnt_q <= sample_cnt_d;
            ovf_q        <= ovf_d;
            done_q       <= done_d;
            ldctrl_q     <= ldctrl_d;
            enable_q     <= enable_d;
        end
    end

endmodule

// File: tb/tb_adc_acq_ctrl.sv
// Testbench for adc_acq_ctrl: scoreboard of expected stream beats plus per-scenario tasks.
module tb_adc_acq_ctrl;

    localparam int CFG_WAIT   = 256;
    localparam int FIFO_DEPTH = 16;
    localparam int CNT_W      = 24;

    logic             clk;
    logic             rst;
    logic             start;
    logic             abort;
    logic [9:0]       cfg_ctrlword;
    logic [15:0]      cfg_df;
    logic [CNT_W-1:0] cfg_nsamp;
    logic             busy;
    logic             done;
    logic             ovf;
    logic [CNT_W-1:0] sample_cnt;
    logic [9:0]       adc_ctrlword;
    logic             adc_ldctrl;
    logic [15:0]      adc_df;
    logic             adc_enable;
    logic [31:0]      adc_douta;
    logic             adc_valida;
    logic [31:0]      m_data;
    logic             m_valid;
    logic             m_ready;
    logic             m_last;

    int n_cmp = 0;
    int n_err = 0;
    int beat_cnt = 0;
    int last_cnt = 0;
    int ldctrl_cnt = 0;
    int done_cnt = 0;
    int enable_cnt = 0;
    logic [32:0] exp_q [$];

    adc_acq_ctrl #(
        .CFG_WAIT   (CFG_WAIT),
        .FIFO_DEPTH (FIFO_DEPTH),
        .CNT_W      (CNT_W)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .abort        (abort),
        .cfg_ctrlword (cfg_ctrlword),
        .cfg_df       (cfg_df),
        .cfg_nsamp    (cfg_nsamp),
        .busy         (busy),
        .done         (done),
        .ovf          (ovf),
        .sample_cnt   (sample_cnt),
        .adc_ctrlword (adc_ctrlword),
        .adc_ldctrl   (adc_ldctrl),
        .adc_df       (adc_df),
        .adc_enable   (adc_enable),
        .adc_douta    (adc_douta),
        .adc_valida   (adc_valida),
        .m_data       (m_data),
        .m_valid      (m_valid),
        .m_ready      (m_ready),
        .m_last       (m_last)
    );

    // Free-running 100 MHz clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Output monitor on the falling edge: counts pulses and checks every beat against the scoreboard.
    always @(negedge clk) begin
        logic [32:0] exp_item;
        if (adc_ldctrl) ldctrl_cnt++;
        if (done) done_cnt++;
        if (adc_enable) enable_cnt++;
        if (m_valid && m_ready && !rst) begin
            beat_cnt++;
            if (m_last) last_cnt++;
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("[TB] FAIL beat_unexpected: got data=%h last=%b, required no beat", m_data, m_last);
            end else begin
                exp_item = exp_q.pop_front();
                if ({m_last, m_data} !== exp_item) begin
                    n_err++;
                    $display("[TB] FAIL beat_data: got {last,data}=%h, required %h", {m_last, m_data}, exp_item);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_counts();
        beat_cnt   = 0;
        last_cnt   = 0;
        ldctrl_cnt = 0;
        done_cnt   = 0;
        enable_cnt = 0;
    endtask

    task automatic do_start(input logic [9:0] cw, input logic [15:0] df, input logic [CNT_W-1:0] ns);
        cfg_ctrlword = cw;
        cfg_df       = df;
        cfg_nsamp    = ns;
        start        = 1'b1;
        tick();
        start        = 1'b0;
    endtask

    task automatic strobe(input logic [31:0] d, input bit expect_beat, input bit is_last);
        adc_douta  = d;
        adc_valida = 1'b1;
        if (expect_beat) exp_q.push_back({is_last, d});
        tick();
        adc_valida = 1'b0;
    endtask

    task automatic wait_enable(output bit ok);
        int w = 0;
        while (!adc_enable && w < 400) begin
            tick();
            w++;
        end
        ok = adc_enable;
    endtask

    task automatic wait_done(output bit ok);
        int w = 0;
        while (done_cnt == 0 && w < 200) begin
            tick();
            w++;
        end
        ok = (done_cnt != 0);
        repeat (3) tick();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) tick();
        n_cmp++;
        if ({busy, done, ovf, adc_ldctrl, adc_enable, m_valid, m_last} !== 7'b0) begin
            n_err++;
            $display("[TB] FAIL reset_flags: got %b, required 0000000", {busy, done, ovf, adc_ldctrl, adc_enable, m_valid, m_last});
        end
        n_cmp++;
        if ({sample_cnt, adc_ctrlword, adc_df, m_data} !== '0) begin
            n_err++;
            $display("[TB] FAIL reset_words: got cnt=%h cw=%h df=%h data=%h, required all 0", sample_cnt, adc_ctrlword, adc_df, m_data);
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_basic();
        bit ok;
        int lat;
        clear_counts();
        m_ready = 1'b1;
        do_start(10'h2A5, 16'd1, 24'd4);
        n_cmp++;
        if ({busy, adc_ctrlword, adc_df} !== {1'b1, 10'h2A5, 16'd1}) begin
            n_err++;
            $display("[TB] FAIL basic_latch: got busy=%b cw=%h df=%h, required 1 2a5 1", busy, adc_ctrlword, adc_df);
        end
        lat = 0;
        do begin
            tick();
            lat++;
        end while (!adc_enable && lat < 400);
        n_cmp++;
        if (lat != CFG_WAIT + 1) begin
            n_err++;
            $display("[TB] FAIL basic_enable_latency: got %0d, required %0d", lat, CFG_WAIT + 1);
        end
        n_cmp++;
        if (ldctrl_cnt != 1) begin
            n_err++;
            $display("[TB] FAIL basic_ldctrl_pulses: got %0d, required 1", ldctrl_cnt);
        end
        for (int k = 0; k < 4; k++) begin
            strobe(32'hA000_0000 + 32'(k * 17), 1'b1, k == 3);
            if (k < 3) repeat (36) tick();
        end
        n_cmp++;
        if (adc_enable !== 1'b0) begin
            n_err++;
            $display("[TB] FAIL basic_enable_off: got %b, required 0", adc_enable);
        end
        wait_done(ok);
        n_cmp++;
        if (!ok || done_cnt != 1 || busy !== 1'b0) begin
            n_err++;
            $display("[TB] FAIL basic_done: got done cycles=%0d busy=%b, required 1 0", done_cnt, busy);
        end
        n_cmp++;
        if (beat_cnt != 4 || last_cnt != 1 || exp_q.size() != 0) begin
            n_err++;
            $display("[TB] FAIL basic_beats: got beats=%0d lasts=%0d pending=%0d, required 4 1 0", beat_cnt, last_cnt, exp_q.size());
        end
        n_cmp++;
        if (ovf !== 1'b0 || sample_cnt !== 24'd4) begin
            n_err++;
            $display("[TB] FAIL basic_status: got ovf=%b cnt=%0d, required 0 4", ovf, sample_cnt);
        end
    endtask

    task automatic test_nsamp_zero();
        clear_counts();
        do_start(10'h155, 16'd7, 24'd0);
        repeat (5) tick();
        n_cmp++;
        if (done_cnt != 1 || ldctrl_cnt != 0 || enable_cnt != 0 || beat_cnt != 0) begin
            n_err++;
            $display("[TB] FAIL zero_run: got done=%0d ld=%0d en=%0d beats=%0d, required 1 0 0 0", done_cnt, ldctrl_cnt, enable_cnt, beat_cnt);
        end
        n_cmp++;
        if (busy !== 1'b0 || adc_df !== 16'd7) begin
            n_err++;
            $display("[TB] FAIL zero_state: got busy=%b df=%0d, required 0 7", busy, adc_df);
        end
    endtask

    task automatic test_overflow();
        bit ok;
        logic [32:0] head;
        clear_counts();
        m_ready = 1'b0;
        do_start(10'h0C3, 16'd2, 24'd20);
        wait_enable(ok);
        n_cmp++;
        if (!ok) begin
            n_err++;
            $display("[TB] FAIL ovf_enable_timeout: got enable=%b, required 1", adc_enable);
        end
        for (int k = 0; k < 20; k++) begin
            strobe(32'h5500_0000 | 32'(k), k < FIFO_DEPTH, 1'b0);
            tick();
        end
        n_cmp++;
        if (ovf !== 1'b1 || sample_cnt !== 24'd16 || adc_enable !== 1'b0) begin
            n_err++;
            $display("[TB] FAIL ovf_status: got ovf=%b cnt=%0d en=%b, required 1 16 0", ovf, sample_cnt, adc_enable);
        end
        head = exp_q[0];
        repeat (3) tick();
        n_cmp++;
        if ({m_valid, m_last, m_data} !== {1'b1, head}) begin
            n_err++;
            $display("[TB] FAIL ovf_stall_hold: got v=%b last=%b data=%h, required 1 %h", m_valid, m_last, m_data, head);
        end
        m_ready = 1'b1;
        wait_done(ok);
        n_cmp++;
        if (!ok || done_cnt != 1 || beat_cnt != 16 || last_cnt != 0 || exp_q.size() != 0) begin
            n_err++;
            $display("[TB] FAIL ovf_drain: got done=%0d beats=%0d lasts=%0d pending=%0d, required 1 16 0 0", done_cnt, beat_cnt, last_cnt, exp_q.size());
        end
    endtask

    task automatic test_abort();
        bit ok;
        int w;
        clear_counts();
        m_ready = 1'b1;
        do_start(10'h011, 16'd1, 24'd10);
        wait_enable(ok);
        for (int k = 0; k < 3; k++) begin
            strobe(32'hC0DE_0000 | 32'(k), 1'b1, 1'b0);
            repeat (3) tick();
        end
        w = 0;
        while (beat_cnt < 3 && w < 20) begin
            tick();
            w++;
        end
        n_cmp++;
        if (!ok || beat_cnt != 3) begin
            n_err++;
            $display("[TB] FAIL abort_pre_beats: got %0d, required 3", beat_cnt);
        end
        m_ready = 1'b0;
        strobe(32'hDEAD_0001, 1'b0, 1'b0);
        strobe(32'hDEAD_0002, 1'b0, 1'b0);
        n_cmp++;
        if (m_valid !== 1'b1) begin
            n_err++;
            $display("[TB] FAIL abort_pre_valid: got %b, required 1", m_valid);
        end
        abort = 1'b1;
        tick();
        abort = 1'b0;
        n_cmp++;
        if ({adc_enable, m_valid, busy} !== 3'b000) begin
            n_err++;
            $display("[TB] FAIL abort_effect: got en/valid/busy=%b, required 000", {adc_enable, m_valid, busy});
        end
        m_ready = 1'b1;
        repeat (10) tick();
        n_cmp++;
        if (done_cnt != 0 || beat_cnt != 3) begin
            n_err++;
            $display("[TB] FAIL abort_after: got done=%0d beats=%0d, required 0 3", done_cnt, beat_cnt);
        end
    endtask

    task automatic test_start_ignored();
        bit ok;
        clear_counts();
        m_ready = 1'b1;
        do_start(10'h0F0, 16'd3, 24'd2);
        tick();
        do_start(10'h30F, 16'd9, 24'd7);
        repeat (3) tick();
        n_cmp++;
        if (adc_ctrlword !== 10'h0F0 || adc_df !== 16'd3 || ldctrl_cnt != 1) begin
            n_err++;
            $display("[TB] FAIL busy_start: got cw=%h df=%0d ld=%0d, required 0f0 3 1", adc_ctrlword, adc_df, ldctrl_cnt);
        end
        wait_enable(ok);
        strobe(32'h1234_5678, 1'b1, 1'b0);
        strobe(32'h9ABC_DEF0, 1'b1, 1'b1);
        wait_done(ok);
        n_cmp++;
        if (!ok || done_cnt != 1 || beat_cnt != 2 || last_cnt != 1) begin
            n_err++;
            $display("[TB] FAIL busy_run: got done=%0d beats=%0d lasts=%0d, required 1 2 1", done_cnt, beat_cnt, last_cnt);
        end
        clear_counts();
        cfg_ctrlword = 10'h3C3;
        cfg_df       = 16'd11;
        cfg_nsamp    = 24'd0;
        start        = 1'b1;
        abort        = 1'b1;
        tick();
        start        = 1'b0;
        abort        = 1'b0;
        repeat (3) tick();
        n_cmp++;
        if (busy !== 1'b0 || done_cnt != 0 || adc_ctrlword !== 10'h0F0 || adc_df !== 16'd3) begin
            n_err++;
            $display("[TB] FAIL start_abort_idle: got busy=%b done=%0d cw=%h df=%0d, required 0 0 0f0 3", busy, done_cnt, adc_ctrlword, adc_df);
        end
    endtask

    task automatic test_df_zero();
        do_start(10'h001, 16'd0, 24'd0);
        repeat (3) tick();
        n_cmp++;
        if (adc_df !== 16'd1 || adc_ctrlword !== 10'h001) begin
            n_err++;
            $display("[TB] FAIL df_zero: got df=%0d cw=%h, required 1 001", adc_df, adc_ctrlword);
        end
    endtask

    task automatic test_reset_mid_acq();
        bit ok;
        clear_counts();
        m_ready = 1'b0;
        do_start(10'h3FF, 16'd5, 24'd5);
        wait_enable(ok);
        strobe(32'hFEED_BEEF, 1'b0, 1'b0);
        tick();
        n_cmp++;
        if (!ok || m_valid !== 1'b1 || adc_enable !== 1'b1) begin
            n_err++;
            $display("[TB] FAIL rst_mid_pre: got valid=%b en=%b, required 1 1", m_valid, adc_enable);
        end
        rst = 1'b1;
        tick();
        n_cmp++;
        if ({busy, done, ovf, sample_cnt, adc_ctrlword, adc_ldctrl, adc_df, adc_enable, m_data, m_valid, m_last} !== '0) begin
            n_err++;
            $display("[TB] FAIL rst_mid_outputs: got busy=%b cnt=%0d cw=%h df=%0d en=%b valid=%b data=%h, required all 0", busy, sample_cnt, adc_ctrlword, adc_df, adc_enable, m_valid, m_data);
        end
        rst = 1'b0;
        m_ready = 1'b1;
        repeat (2) tick();
    endtask

    // Scenario sequence followed by the one-line summary.
    initial begin
        rst          = 1'b1;
        start        = 1'b0;
        abort        = 1'b0;
        cfg_ctrlword = '0;
        cfg_df       = '0;
        cfg_nsamp    = '0;
        adc_douta    = '0;
        adc_valida   = 1'b0;
        m_ready      = 1'b0;
        test_reset();
        test_basic();
        test_nsamp_zero();
        test_overflow();
        test_abort();
        test_start_ignored();
        test_df_zero();
        test_reset_mid_acq();
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("[TB] FAIL scoreboard_leftover: got %0d pending, required 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
